write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer.sv | 152 +++++++++++++++
 tb/tb_write_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// Write-through buffer between a cache and main memory. It queues writes, serves read
// hits from buffered data and keeps at most one memory transaction outstanding.
module write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAdd,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrReady,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAdd,
  output logic              rdReady,
  output logic              rdValid,
  output logic [DATA_W-1:0] rdData,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAdd,
  output logic [DATA_W-1:0] memWData,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRData
);
  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t            state, next_state;
  logic [PTR_W-1:0]  head, tail, idx;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic              push, pop, rd_accept, hit, start_read, start_drain, read_done;
  logic [DATA_W-1:0] hit_data;

  assign wrReady   = (count < FULL_COUNT);
  assign rdReady   = (state == IDLE) && !rdValid && (count != FULL_COUNT);
  assign push      = wrReq && wrReady;
  assign rd_accept = rdReq && rdReady;

  // Scan oldest to youngest so the last match wins; a same-cycle write is youngest of all.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (buf_addr[idx][ADDR_W-1:2] == rdAdd[ADDR_W-1:2])) begin
        hit      = 1'b1;
        hit_data = buf_data[idx];
      end
    end
    if (push && (wrAdd[ADDR_W-1:2] == rdAdd[ADDR_W-1:2])) begin
      hit      = 1'b1;
      hit_data = wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_read  = 1'b0;
    start_drain = 1'b0;
    pop         = 1'b0;
    read_done   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_accept && !hit) begin
          next_state = READ;
          start_read = 1'b1;
        end else if (!rd_accept && (count != '0)) begin
          next_state  = DRAIN;
          start_drain = 1'b1;
        end
      end
      DRAIN: begin
        if (memAck) begin
          next_state = IDLE;
          pop        = 1'b1;
        end
      end
      READ: begin
        if (memAck) begin
          next_state = IDLE;
          read_done  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= wrAdd;
      buf_data[tail] <= wrData;
    end
  end

  // The head entry stays valid for read matching until its drain is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAdd   <= '0;
      memWData <= '0;
      rdValid  <= 1'b0;
      rdData   <= '0;
    end else begin
      rdValid <= 1'b0;
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (start_drain) begin
        memReq   <= 1'b1;
        memWe    <= 1'b1;
        memAdd   <= buf_addr[head];
        memWData <= buf_data[head];
      end else if (start_read) begin
        memReq <= 1'b1;
        memWe  <= 1'b0;
        memAdd <= rdAdd;
      end
      if (pop || read_done) begin
        memReq <= 1'b0;
        memWe  <= 1'b0;
      end
      if (read_done) begin
        rdData  <= memRData;
        rdValid <= 1'b1;
      end else if (rd_accept && hit) begin
        rdData  <= hit_data;
        rdValid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: a vector table of single transactions, directed
// corner sequences, then random traffic checked against a queue-based reference model.
module tb_write_buffer;
  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        wrReq, rdReq, memAck;
  logic [31:0] wrAdd, wrData, rdAdd, memRData;
  logic        wrReady, rdReady, rdValid, memReq, memWe;
  logic [31:0] rdData, memAdd, memWData;

  int total = 0;
  int bad   = 0;

  write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wrReq(wrReq), .wrAdd(wrAdd), .wrData(wrData), .wrReady(wrReady),
    .rdReq(rdReq), .rdAdd(rdAdd), .rdReady(rdReady), .rdValid(rdValid), .rdData(rdData),
    .memReq(memReq), .memWe(memWe), .memAdd(memAdd), .memWData(memWData),
    .memAck(memAck), .memRData(memRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] add;
    logic [31:0] data;
    int          ack_dly;
    logic        exp_we;
    logic [31:0] exp_add;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  // Reference model: buffered writes in acceptance order plus a word-addressed memory.
  logic [31:0] mq_add[$];
  logic [31:0] mq_dat[$];
  logic [31:0] mem_model [logic [29:0]];
  bit          rd_due, miss_pend, txn_seen;
  logic [31:0] rd_exp, miss_add;
  int          ack_wait;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memVal(input logic [31:0] a);
    if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  task automatic doReset();
    wrReq = 1'b0; rdReq = 1'b0; memAck = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitMemReq(input string name);
    int n = 0;
    while (!memReq && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_req"}, 32'(memReq), 32'd1);
  endtask

  task automatic expectWrite(input string name, input logic [31:0] ea, input logic [31:0] ed);
    waitMemReq(name);
    checkOutput({name, "_we"}, 32'(memWe), 32'd1);
    checkOutput({name, "_add"}, memAdd, ea);
    checkOutput({name, "_wdata"}, memWData, ed);
    @(negedge clk);
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput({name, "_drop"}, 32'(memReq), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int k);
    string tag = $sformatf("vec%0d", k);
    if (v.is_read) begin
      checkOutput({tag, "_rdready"}, 32'(rdReady), 32'd1);
      rdReq = 1'b1; rdAdd = v.add;
    end else begin
      wrReq = 1'b1; wrAdd = v.add; wrData = v.data;
    end
    @(negedge clk);
    rdReq = 1'b0; wrReq = 1'b0;
    waitMemReq(tag);
    checkOutput({tag, "_we"}, 32'(memWe), 32'(v.exp_we));
    checkOutput({tag, "_add"}, memAdd, v.exp_add);
    if (!v.is_read) checkOutput({tag, "_wdata"}, memWData, v.exp_wdata);
    for (int i = 0; i < v.ack_dly; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold"}, 32'(memReq), 32'd1);
      checkOutput({tag, "_hold_add"}, memAdd, v.exp_add);
    end
    memRData = v.data;
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput({tag, "_drop"}, 32'(memReq), 32'd0);
    if (v.is_read) begin
      checkOutput({tag, "_rdvalid"}, 32'(rdValid), 32'd1);
      checkOutput({tag, "_rddata"}, rdData, v.exp_rdata);
      @(negedge clk);
      checkOutput({tag, "_rdpulse"}, 32'(rdValid), 32'd0);
    end else begin
      checkOutput({tag, "_wrready"}, 32'(wrReady), 32'd1);
    end
  endtask

  task automatic rndCycle(input bit allow);
    bit          wr, rd, hit;
    logic [31:0] a, d, ra;
    @(negedge clk);
    checkOutput("rnd_valid", 32'(rdValid), 32'(rd_due));
    if (rd_due && rdValid) checkOutput("rnd_rddata", rdData, rd_exp);
    rd_due = 1'b0;
    checkOutput("rnd_wrready", 32'(wrReady), 32'(mq_add.size() < DEPTH));
    if (mq_add.size() == DEPTH) checkOutput("rnd_rdready_full", 32'(rdReady), 32'd0);
    memAck = 1'b0;
    if (memReq) begin
      if (!txn_seen) begin
        txn_seen = 1'b1;
        ack_wait = int'($urandom_range(0, 4));
        if (memWe) begin
          checkOutput("rnd_wr_pending", 32'(mq_add.size() != 0), 32'd1);
          if (mq_add.size() != 0) begin
            checkOutput("rnd_wr_add", memAdd, mq_add[0]);
            checkOutput("rnd_wr_data", memWData, mq_dat[0]);
          end
        end else begin
          checkOutput("rnd_rd_expected", 32'(miss_pend), 32'd1);
          checkOutput("rnd_rd_add", memAdd, miss_add);
        end
      end
      if (ack_wait == 0) begin
        memAck = 1'b1;
        txn_seen = 1'b0;
        if (memWe) begin
          if (mq_add.size() != 0) begin
            mem_model[mq_add[0][31:2]] = mq_dat[0];
            void'(mq_add.pop_front());
            void'(mq_dat.pop_front());
          end
        end else begin
          memRData  = memVal(miss_add);
          rd_exp    = memRData;
          rd_due    = 1'b1;
          miss_pend = 1'b0;
        end
      end else begin
        ack_wait--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      memAck = 1'b1;
      memRData = $urandom;
    end
    wr = allow && ($urandom_range(0, 1) == 1);
    rd = allow && ($urandom_range(0, 2) == 0);
    a  = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
    ra = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
    d  = $urandom;
    wrReq = wr; wrAdd = a; wrData = d;
    rdReq = rd; rdAdd = ra;
    if (wr && wrReady) begin
      mq_add.push_back(a);
      mq_dat.push_back(d);
    end
    if (rd && rdReady) begin
      hit = 1'b0;
      for (int i = mq_add.size() - 1; i >= 0 && !hit; i--) begin
        if (mq_add[i][31:2] == ra[31:2]) begin
          hit = 1'b1;
          rd_exp = mq_dat[i];
        end
      end
      if (hit) rd_due = 1'b1;
      else begin
        miss_pend = 1'b1;
        miss_add  = ra;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{1'b0, 32'h40,        32'd111,        3, 1'b1, 32'h40,        32'd111,        32'd0};
    vecs[1] = '{1'b0, 32'h440,       32'd222,        3, 1'b1, 32'h440,       32'd222,        32'd0};
    vecs[2] = '{1'b1, 32'h1C40,      32'd333,        2, 1'b0, 32'h1C40,      32'd0,          32'd333};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF,  0, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF,  32'd0};
    vecs[4] = '{1'b1, 32'h1C43,      32'h1234_5678,  1, 1'b0, 32'h1C43,      32'd0,          32'h1234_5678};

    wrReq = 1'b0; rdReq = 1'b0; memAck = 1'b0; rst_n = 1'b0;
    wrAdd = '0; wrData = '0; rdAdd = '0; memRData = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_memreq", 32'(memReq), 32'd0);
    checkOutput("rst_memwe", 32'(memWe), 32'd0);
    checkOutput("rst_rdvalid", 32'(rdValid), 32'd0);
    checkOutput("rst_memadd", memAdd, 32'd0);
    checkOutput("rst_memwdata", memWData, 32'd0);
    checkOutput("rst_rddata", rdData, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_wrready", 32'(wrReady), 32'd1);
    checkOutput("rst_rdready", 32'(rdReady), 32'd1);

    for (int k = 0; k < 5; k++) applyStimulus(vecs[k], k);

    // Read hit on a buffered write while its drain has not started yet.
    wrReq = 1'b1; wrAdd = 32'h840; wrData = 32'd5000;
    @(negedge clk);
    wrReq = 1'b0;
    checkOutput("hit_rdready", 32'(rdReady), 32'd1);
    rdReq = 1'b1; rdAdd = 32'h840;
    @(negedge clk);
    rdReq = 1'b0;
    checkOutput("hit_valid", 32'(rdValid), 32'd1);
    checkOutput("hit_data", rdData, 32'd5000);
    checkOutput("hit_nomem", 32'(memReq), 32'd0);
    @(negedge clk);
    checkOutput("hit_pulse", 32'(rdValid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hit_drain_we", 32'(memReq && memWe), 32'd1);
      @(negedge clk);
    end
    expectWrite("hit_drain", 32'h840, 32'd5000);

    // Youngest match: first against a same-cycle write, then among buffered entries.
    wrReq = 1'b1; wrAdd = 32'h40; wrData = 32'd1;
    @(negedge clk);
    checkOutput("young_rdready", 32'(rdReady), 32'd1);
    wrData = 32'd2; rdReq = 1'b1; rdAdd = 32'h40;
    @(negedge clk);
    wrReq = 1'b0; rdReq = 1'b0;
    checkOutput("young_same_valid", 32'(rdValid), 32'd1);
    checkOutput("young_same_data", rdData, 32'd2);
    expectWrite("young_w1", 32'h40, 32'd1);
    expectWrite("young_w2", 32'h40, 32'd2);
    for (int i = 1; i <= 3; i++) begin
      wrReq = 1'b1; wrAdd = 32'h40; wrData = 32'(i);
      @(negedge clk);
    end
    wrReq = 1'b0;
    checkOutput("young_drain_wdata", memWData, 32'd1);
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("young_buf_rdready", 32'(rdReady), 32'd1);
    rdReq = 1'b1; rdAdd = 32'h40;
    @(negedge clk);
    rdReq = 1'b0;
    checkOutput("young_buf_data", rdData, 32'd3);
    expectWrite("young_w3", 32'h40, 32'd2);
    expectWrite("young_w4", 32'h40, 32'd3);

    // Fill to DEPTH with memory stalled; the fifth write and a read miss must wait.
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_wrready_pre", 32'(wrReady), 32'd1);
      wrReq = 1'b1; wrAdd = 32'h100 + 32'(i * 4); wrData = 32'(10 + i);
      @(negedge clk);
    end
    wrAdd = 32'h110; wrData = 32'd14; rdReq = 1'b1; rdAdd = 32'h200;
    checkOutput("full_drain_add", memAdd, 32'h100);
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_wrready", 32'(wrReady), 32'd0);
      checkOutput("full_rdready", 32'(rdReady), 32'd0);
      if (i < 3) @(negedge clk);
    end
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("full_wrready_after", 32'(wrReady), 32'd1);
    checkOutput("full_rdready_after", 32'(rdReady), 32'd1);
    @(negedge clk);
    wrReq = 1'b0; rdReq = 1'b0;
    checkOutput("full_miss_req", 32'(memReq), 32'd1);
    checkOutput("full_miss_we", 32'(memWe), 32'd0);
    checkOutput("full_miss_add", memAdd, 32'h200);
    checkOutput("full_refilled", 32'(wrReady), 32'd0);
    memRData = 32'h55; memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("full_miss_data", rdData, 32'h55);
    for (int i = 1; i < 5; i++) expectWrite($sformatf("full_order%0d", i), 32'h100 + 32'(i * 4), 32'(10 + i));
    repeat (4) begin
      @(negedge clk);
      checkOutput("full_no_extra", 32'(memReq), 32'd0);
    end

    // Reset while a drain is outstanding, then a stray acknowledge afterwards.
    wrReq = 1'b1; wrAdd = 32'h300; wrData = 32'd77;
    @(negedge clk);
    wrReq = 1'b0;
    waitMemReq("rstmid");
    #2 rst_n = 1'b0;
    #1 checkOutput("rstmid_memreq", 32'(memReq), 32'd0);
    checkOutput("rstmid_wrready", 32'(wrReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    checkOutput("rstmid_rdready", 32'(rdReady), 32'd1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("rstmid_quiet", 32'(memReq), 32'd0);
    end

    doReset();
    mq_add.delete(); mq_dat.delete(); mem_model.delete();
    rd_due = 1'b0; miss_pend = 1'b0; txn_seen = 1'b0; ack_wait = 0;
    for (int c = 0; c < 3000; c++) rndCycle(1'b1);
    for (int c = 0; c < 300 && (mq_add.size() != 0 || miss_pend || rd_due || txn_seen); c++) rndCycle(1'b0);
    checkOutput("rnd_drained", 32'(mq_add.size() == 0 && !miss_pend && !rd_due), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
